// File: rtl/divider16.sv
// rtl/divider16.sv - 16/8 restoring divider; DIVIDER16_SIGNED_EN selects two's complement mode
module divider16 (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] x,
    input  logic [7:0]  y,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ovf,
    output logic        divz,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, next_state;
    logic [3:0]  count;
    logic [15:0] quo;
    logic [7:0]  rem;
    logic [7:0]  dvs;
    logic [15:0] x_mag;
    logic [7:0]  y_mag;
    logic [8:0]  rem_sh;
    logic        lt;
    logic [7:0]  diff;
    logic [7:0]  q_fix;
    logic [7:0]  r_fix;
    logic        ovf_fix;

`ifdef DIVIDER16_SIGNED_EN
    logic neg_q, neg_r;

    // Unsigned 16/8-bit magnitudes keep 32768 and 128 exact.
    assign x_mag = x[15] ? (~x + 16'd1) : x;
    assign y_mag = y[7]  ? (~y + 8'd1)  : y;
`else
    assign x_mag = x;
    assign y_mag = y;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = CALC;
            CALC:    if (count == 4'd15) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem, quo[15]};
        lt     = !rem_sh[8] && (rem_sh[7:0] < dvs);
        diff   = rem_sh[7:0] - dvs;
    end

    always_comb begin
        q_fix   = 8'h00;
        r_fix   = 8'h00;
        ovf_fix = 1'b0;
`ifdef DIVIDER16_SIGNED_EN
        if (neg_q) begin
            if (quo > 16'd128) begin
                q_fix   = 8'h80;
                ovf_fix = 1'b1;
            end else begin
                q_fix = 8'd0 - quo[7:0];
            end
        end else if (quo > 16'd127) begin
            q_fix   = 8'h7F;
            ovf_fix = 1'b1;
        end else begin
            q_fix = quo[7:0];
        end
        r_fix = neg_r ? (8'd0 - rem) : rem;
`else
        if (quo > 16'd255) begin
            q_fix   = 8'hFF;
            ovf_fix = 1'b1;
        end else begin
            q_fix = quo[7:0];
        end
        r_fix = rem;
`endif
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= 4'd0;
            quo   <= 16'd0;
            rem   <= 8'd0;
            dvs   <= 8'd0;
            q     <= 8'd0;
            r     <= 8'd0;
            ovf   <= 1'b0;
            divz  <= 1'b0;
`ifdef DIVIDER16_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quo   <= x_mag;
                        rem   <= 8'd0;
                        dvs   <= y_mag;
                        count <= 4'd0;
`ifdef DIVIDER16_SIGNED_EN
                        neg_q <= x[15] ^ y[7];
                        neg_r <= x[15];
`endif
                    end
                end
                CALC: begin
                    quo   <= {quo[14:0], !lt};
                    rem   <= lt ? rem_sh[7:0] : diff;
                    count <= count + 4'd1;
                end
                FIX: begin
                    if (dvs == 8'd0) begin
                        q    <= 8'h00;
                        r    <= 8'h00;
                        ovf  <= 1'b0;
                        divz <= 1'b1;
                    end else begin
                        q    <= q_fix;
                        r    <= r_fix;
                        ovf  <= ovf_fix;
                        divz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider16.sv
// tb/tb_divider16.sv - scoreboard bench for divider16 in either DIVIDER16_SIGNED_EN build
module tb_divider16;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       divz;
    } exp_t;

    // Edges counted with the accept edge as edge 1.
    localparam int LATENCY = 18;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] x = 16'd0;
    logic [7:0]  y = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        divz;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    divider16 dut (
        .clock     (clock),
        .resetn    (resetn),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .ovf       (ovf),
        .divz      (divz),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [15:0] xv, input logic [7:0] yv);
        exp_t   e;
        integer xi, yi, qt, rt;
        e = '0;
        if (yv == 8'd0) begin
            e.divz = 1'b1;
            return e;
        end
`ifdef DIVIDER16_SIGNED_EN
        xi = $signed(xv);
        yi = $signed(yv);
        qt = xi / yi;
        rt = xi % yi;
        if (qt > 127) begin
            e.q = 8'h7F; e.ovf = 1'b1;
        end else if (qt < -128) begin
            e.q = 8'h80; e.ovf = 1'b1;
        end else begin
            e.q = qt[7:0];
        end
`else
        xi = {16'd0, xv};
        yi = {24'd0, yv};
        qt = xi / yi;
        rt = xi % yi;
        if (qt > 255) begin
            e.q = 8'hFF; e.ovf = 1'b1;
        end else begin
            e.q = qt[7:0];
        end
`endif
        e.r = rt[7:0];
        return e;
    endfunction

    task automatic run_op(input logic [15:0] xv, input logic [7:0] yv, input int hold);
        exp_t e;
        int   edges;
        logic busy_ok;
        @(negedge clock);
        x = xv;
        y = yv;
        in_valid = 1'b1;
        sb.push_back(model(xv, yv));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        x = 16'($urandom);
        y = 8'($urandom);
        edges = 1;
        busy_ok = 1'b1;
        while (!out_valid && edges < LATENCY + 20) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clock);
            #1;
            edges++;
        end
        tests_run++;
        if (edges !== LATENCY || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency x=%h y=%h: got %0d edges (out_valid=%b), want %0d", xv, yv, edges, out_valid, LATENCY);
        end
        tests_run++;
        if (!busy_ok) begin
            tests_failed++;
            $display("FAIL busy_in_ready x=%h y=%h: in_ready=1 while busy, want 0", xv, yv);
        end
        e = sb.pop_front();
        tests_run++;
        if ({q, r, ovf, divz} !== e) begin
            tests_failed++;
            $display("FAIL result x=%h y=%h: got q=%h r=%h ovf=%b divz=%b, want q=%h r=%h ovf=%b divz=%b",
                     xv, yv, q, r, ovf, divz, e.q, e.r, e.ovf, e.divz);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            in_valid = (i == 3);
            x = 16'($urandom);
            @(posedge clock);
            #1;
            tests_run++;
            if ({q, r, ovf, divz} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got q=%h r=%h ovf=%b divz=%b ov=%b ir=%b, want q=%h r=%h ovf=%b divz=%b ov=1 ir=0",
                         i, q, r, ovf, divz, out_valid, in_ready, e.q, e.r, e.ovf, e.divz);
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release: got out_valid=%b in_ready=%b, want 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        int seen;
        resetn = 1'b0;
        in_valid = 1'b1;
        x = 16'd5;
        y = 8'd1;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 8'h00 || r !== 8'h00 || ovf !== 1'b0 || divz !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got ir=%b ov=%b q=%h r=%h ovf=%b divz=%b, want 1 0 00 00 0 0",
                     in_ready, out_valid, q, r, ovf, divz);
        end
        @(negedge clock);
        resetn = 1'b1;
        in_valid = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (out_valid || !in_ready) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL reset_wins: got %0d busy cycles after reset with in_valid, want 0", seen);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] xs[8];
        logic [7:0]  ys[8];
        xs = '{16'd100, 16'hFF9C, 16'h8000, 16'd1000, 16'hFFF9, 16'h7FFF, 16'd0, 16'hFFFF};
        ys = '{8'd7,    8'd7,     8'h80,    8'd3,     8'd2,     8'hFF,    8'd5,  8'hFF};
        for (int i = 0; i < 8; i++) run_op(xs[i], ys[i], 0);
    endtask

    task automatic test_divz();
        run_op(16'd1000, 8'd0, 0);
        run_op(16'h8000, 8'd0, 0);
    endtask

    task automatic test_backpressure();
        run_op(16'd100, 8'd7, 10);
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_in_valid: got in_ready=%b out_valid=%b, want 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clock);
        x = 16'd1234;
        y = 8'd9;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 8'h00 || r !== 8'h00 || ovf !== 1'b0 || divz !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: got ir=%b ov=%b q=%h r=%h ovf=%b divz=%b, want 1 0 00 00 0 0",
                     in_ready, out_valid, q, r, ovf, divz);
        end
        @(negedge clock);
        resetn = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL abort_silent: got %0d out_valid cycles, want 0", seen);
        end
        run_op(16'd1000, 8'd3, 0);
    endtask

    task automatic test_back_to_back();
        run_op(16'd32767, 8'd127, 0);
        run_op(16'h8000, 8'hFF, 0);
        run_op(16'd255, 8'd1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) run_op(16'($urandom), (i == 5) ? 8'd0 : 8'($urandom), 0);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_divz();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
